// File: rtl/alu_mdu.sv
// Integer execution unit: single-cycle RV base ALU ops plus iterative M-extension
// multiply (shift-add) and restoring divide, valid/ready on both sides.
module alu_mdu #(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [XLEN-1:0]   num1,
  input  logic [XLEN-1:0]   num2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN);

  localparam logic [ALUC_W-1:0] OP_JALR   = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] OP_SUB    = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] OP_SLL    = ALUC_W'(3);
  localparam logic [ALUC_W-1:0] OP_SLT    = ALUC_W'(4);
  localparam logic [ALUC_W-1:0] OP_SLTU   = ALUC_W'(5);
  localparam logic [ALUC_W-1:0] OP_XOR    = ALUC_W'(6);
  localparam logic [ALUC_W-1:0] OP_SRL    = ALUC_W'(7);
  localparam logic [ALUC_W-1:0] OP_SRA    = ALUC_W'(8);
  localparam logic [ALUC_W-1:0] OP_OR     = ALUC_W'(9);
  localparam logic [ALUC_W-1:0] OP_AND    = ALUC_W'(10);
  localparam logic [ALUC_W-1:0] OP_MUL    = ALUC_W'(11);
  localparam logic [ALUC_W-1:0] OP_MULH   = ALUC_W'(12);
  localparam logic [ALUC_W-1:0] OP_MULHU  = ALUC_W'(14);
  localparam logic [ALUC_W-1:0] OP_DIV    = ALUC_W'(15);
  localparam logic [ALUC_W-1:0] OP_REM    = ALUC_W'(17);
  localparam logic [ALUC_W-1:0] OP_REMU   = ALUC_W'(18);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   res_q;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [2*XLEN-1:0] prod;
  logic              neg;
  logic              sel;

  logic              accept;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   sum;
  logic [XLEN-1:0]   alu_res;
  logic              is_mul;
  logic              is_div;
  logic              is_rem;
  logic              sa;
  logic              sb;
  logic              da;
  logic              db;
  logic              div0;
  logic              ovf;
  logic              div_sp;
  logic              div_it;
  logic              n1;
  logic              n2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;
  logic [XLEN-1:0]   sp_res;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign result    = res_q;

  assign shamt = num2[SW-1:0];
  assign sum   = num1 + num2;

  always_comb begin
    alu_res = sum;
    case (aluc)
      OP_JALR: alu_res = sum & ~XLEN'(1);
      OP_SUB:  alu_res = num1 - num2;
      OP_SLL:  alu_res = num1 << shamt;
      OP_SLT:  alu_res = XLEN'($signed(num1) < $signed(num2));
      OP_SLTU: alu_res = XLEN'(num1 < num2);
      OP_XOR:  alu_res = num1 ^ num2;
      OP_SRL:  alu_res = num1 >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(num1) >>> shamt);
      OP_OR:   alu_res = num1 | num2;
      OP_AND:  alu_res = num1 & num2;
      default: alu_res = sum;
    endcase
  end

  assign is_mul = (aluc >= OP_MUL) & (aluc <= OP_MULHU);
  assign is_div = (aluc >= OP_DIV) & (aluc <= OP_REMU);
  assign is_rem = (aluc == OP_REM) | (aluc == OP_REMU);

  assign sa = (aluc != OP_MULHU) & num1[XLEN-1];
  assign sb = ((aluc == OP_MUL) | (aluc == OP_MULH)) & num2[XLEN-1];
  assign da = ((aluc == OP_DIV) | (aluc == OP_REM)) & num1[XLEN-1];
  assign db = ((aluc == OP_DIV) | (aluc == OP_REM)) & num2[XLEN-1];

  assign div0 = (num2 == '0);
  assign ovf  = ((aluc == OP_DIV) | (aluc == OP_REM)) &
                (num1 == {1'b1, {(XLEN-1){1'b0}}}) & (num2 == '1);
  assign div_sp = is_div & (div0 | ovf);
  assign div_it = is_div & ~(div0 | ovf);

  assign n1   = is_mul ? sa : da;
  assign n2   = is_mul ? sb : db;
  assign mag1 = n1 ? -num1 : num1;
  assign mag2 = n2 ? -num2 : num2;

  always_comb begin
    if (div0) sp_res = is_rem ? num1 : '1;
    else      sp_res = is_rem ? '0 : num1;
  end

  // one multiplier bit per cycle, MSB first
  logic [2*XLEN-1:0] prod_nx;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mul_res;

  assign prod_nx  = {prod[2*XLEN-2:0], 1'b0} +
                    (opb[cnt] ? {{XLEN{1'b0}}, opa} : '0);
  assign prod_fin = neg ? -prod_nx : prod_nx;
  assign mul_res  = sel ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];

  // restoring divide on magnitudes, one quotient bit per cycle
  logic [XLEN:0]   rsh;
  logic            ge;
  logic [XLEN:0]   rdiff;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] div_res;

  assign rsh    = {rem, opa[cnt]};
  assign ge     = rsh >= {1'b0, opb};
  assign rdiff  = rsh - {1'b0, opb};
  assign rem_nx = ge ? rdiff[XLEN-1:0] : rsh[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ge};

  always_comb begin
    if (sel) div_res = neg ? -rem_nx : rem_nx;
    else     div_res = neg ? -quo_nx : quo_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      quo   <= '0;
      rem   <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      sel   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            opa  <= mag1;
            opb  <= mag2;
            cnt  <= CW'(XLEN-1);
            prod <= '0;
            quo  <= '0;
            rem  <= '0;
            neg  <= is_mul ? (sa ^ sb) : (is_rem ? da : (da ^ db));
            sel  <= is_mul ? (aluc != OP_MUL) : is_rem;
            unique case (1'b1)
              is_mul: state <= MUL;
              div_it: state <= DIV;
              div_sp: begin
                res_q <= sp_res;
                state <= DONE;
              end
              default: begin
                res_q <= alu_res;
                state <= DONE;
              end
            endcase
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        MUL: begin
          prod <= prod_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= mul_res;
            state <= DONE;
          end
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q <= div_res;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu (XLEN=32): base ops, M ops, divide
// corner cases, backpressure, flush and asynchronous reset.
module tb_alu_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      aluc;
  logic [XLEN-1:0] num1;
  logic [XLEN-1:0] num2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int errs   = 0;
  int checks = 0;

  alu_mdu #(.XLEN(XLEN), .ALUC_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluc      (aluc),
    .num1      (num1),
    .num2      (num2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // issue one op, wait for out_valid, check latency and value, then consume
  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat_exp);
    int lat;
    @(negedge clk);
    aluc = op; num1 = a; num2 = b;
    in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".rdy"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    num1 = 32'hdead_beef; num2 = 32'h1234_5678; aluc = 5'd0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, lat, lat_exp);
    check({tag, ".res"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] held;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    aluc = '0; num1 = '0; num2 = '0;
    #12;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run("add",  5'd0,  32'd10,        32'd20,        32'd30,        1);
    run("jalr", 5'd1,  32'h8000_0003, 32'h4,         32'h8000_0006, 1);
    run("sub",  5'd2,  32'd5,         32'd7,         32'hFFFF_FFFE, 1);
    run("sll",  5'd3,  32'h1,         32'h21,        32'h2,         1);
    run("slt",  5'd4,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
    run("sltu", 5'd5,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    run("xor",  5'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    run("srl",  5'd7,  32'hF000_0000, 32'h24,        32'h0F00_0000, 1);
    run("sra",  5'd8,  32'hF000_0000, 32'h24,        32'hFF00_0000, 1);
    run("or",   5'd9,  32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1);
    run("and",  5'd10, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run("op20", 5'd20, 32'd3,         32'd9,         32'd12,        1);

    run("mul",    5'd11, 32'hFFFF_FFF9, 32'd6,    32'hFFFF_FFD6, 33);
    run("mulh",   5'd12, 32'hFFFF_FFFF, 32'h2,    32'hFFFF_FFFF, 33);
    run("mulhu",  5'd14, 32'hFFFF_FFFF, 32'h2,    32'h0000_0001, 33);
    run("mulhsu", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run("div",    5'd15, 32'hFFFF_FFF9, 32'd2,    32'hFFFF_FFFD, 33);
    run("rem",    5'd17, 32'hFFFF_FFF9, 32'd2,    32'hFFFF_FFFF, 33);
    run("divu",   5'd16, 32'd100,       32'd7,    32'd14,        33);
    run("remu",   5'd18, 32'd100,       32'd7,    32'd2,         33);

    run("div0",   5'd15, 32'd5,         32'd0,    32'hFFFF_FFFF, 1);
    run("remu0",  5'd18, 32'd5,         32'd0,    32'd5,         1);
    run("divovf", 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("removf", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,    1);

    // backpressure: DIVU result held while out_ready stays low
    @(negedge clk);
    aluc = 5'd16; num1 = 32'd200; num2 = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp.valid", out_valid, 1'b1);
    held = 32'd22;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_valid", out_valid, 1'b1);
      check("bp.hold_res", result, held);
    end
    aluc = 5'd0; num1 = 32'd1; num2 = 32'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("bp.in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("bp.next_valid", out_valid, 1'b1);
    check("bp.next_res", result, 32'd2);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp.drained", out_valid, 1'b0);

    // flush during a multiply
    aluc = 5'd11; num1 = 32'd3; num2 = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fl.in_ready", in_ready, 1'b1);
    check("fl.out_valid", out_valid, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("fl.never_valid", n, 0);
    run("fl.add", 5'd0, 32'd3, 32'd4, 32'd7, 1);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    aluc = 5'd15; num1 = 32'd1000; num2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rs.busy", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rs.out_valid", out_valid, 1'b0);
    check("rs.result", result, 32'h0);
    check("rs.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run("rs.add", 5'd0, 32'd8, 32'd9, 32'd17, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised multi-cycle integer execution unit for the npc core. It replaces the single-cycle adder with the full RV32/RV64 base ALU op set plus the M extension.
- Base ops complete in one cycle. MUL/DIV families run on iterative shift-add and restoring-divide datapaths.
- Sits between decode/issue and writeback, with valid/ready handshakes on both sides and a flush input for branch redirect.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- ALUC_W, 5, width of the operation code.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the in-flight op.
- in_valid  in  1  operands/op present.
- in_ready  out  1  unit can accept an op this cycle.
- aluc  in  ALUC_W  op code.
- num1  in  XLEN  operand 1 (rs1/pc).
- num2  in  XLEN  operand 2 (rs2/imm).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  result.

Behaviour:
- Op codes:
  - 0 ADD, 1 ADD_JALR ((num1+num2) with bit0 cleared), 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND.
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - Codes 19..31 behave as ADD.
- Shift amount: num2[4:0] for XLEN=32, num2[5:0] for XLEN=64.
- Reset values: in_ready=1, out_valid=0, result=0, FSM=IDLE, all internal accumulators and counters 0.
- FSM states: IDLE, MUL, DIV, DONE.
  - Handshake accept = in_valid & in_ready.
  - in_ready = (IDLE) | (DONE & out_ready).
  - Operands and op are latched only on accept.
- Accept of a base op (0..10): result registered, go to DONE. out_valid=1 in cycle N+1, where N is the accept cycle.
- Accept of MUL*: go to MUL.
  - Latch magnitudes and result sign from the op signedness (MULH s×s, MULHSU s×u, MULHU u×u).
  - One partial-product bit per cycle, counter XLEN-1 down to 0.
  - On counter=0, apply sign correction to the 2·XLEN product, select the low half (MUL) or high half (others), and go to DONE.
  - out_valid at N+XLEN+1.
- Accept of DIV*: go to DIV with a restoring divide on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Negate the quotient if the operand signs differ (signed ops). The remainder takes the dividend's sign.
  - out_valid at N+XLEN+1.
- DIV special cases, resolved on accept, straight to DONE with out_valid at N+1:
  - num2=0: DIV/DIVU give all-ones; REM/REMU give num1.
  - Signed overflow (num1 = most-negative, num2 = -1): DIV gives num1; REM gives 0.
- DONE:
  - result and out_valid are held stable until out_ready=1.
  - out_ready with no new accept → IDLE, out_valid=0 next cycle.
  - out_ready with a simultaneous accept → the new op starts; the old result is never repeated.
- flush=1 in any state → IDLE next cycle and out_valid=0. Any in-flight result is discarded.
  - flush has priority over out_ready and over a same-cycle accept; the accept is dropped.
  - in_ready is unaffected by flush combinationally.
- MUL/DIV ignore in_valid while busy (in_ready=0). The inputs num1/num2/aluc may change freely then.
- rst_n low mid-operation → immediate return to reset values; the partial state is lost.
- All arithmetic wraps modulo 2^XLEN. SLT/SLTU return zero-extended 0 or 1.

Test Plan:
- XLEN=32.
  - ADD_JALR: num1=0x80000003, num2=0x4 → result 0x80000006 at N+1.
  - SRA: num1=0xF0000000, num2=0x24 → 0xFF000000, using shamt 4.
- MULH/MULHU (XLEN=32): num1=0xFFFFFFFF, num2=0x2.
  - MULH → 0xFFFFFFFF at N+33.
  - MULHU → 0x00000001 at N+33.
- DIV/REM (XLEN=32): num1=0xFFFFFFF9 (-7), num2=2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF, each at N+33.
- DIV special cases (XLEN=32), all at N+1:
  - DIV by zero (num1=5, num2=0) → 0xFFFFFFFF.
  - REMU by zero → 5.
  - DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000.
- Backpressure: DIVU completes with out_ready=0 for 5 cycles → result and out_valid stay stable. When out_ready rises with in_valid=1 (ADD 1+1), the next cycle shows result 2 with out_valid=1.
- Flush and reset:
  - flush at cycle 10 of a MUL → out_valid never asserts, in_ready=1 next cycle, and a following ADD 3+4 returns 7.
  - rst_n pulsed low mid-DIV → out_valid=0 and result=0 immediately.
